// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch stage for the RV64 core.
// Issues word fetches over a req/resp port and tracks in-flight PCs in order.
// Buffers {pc,inst} pairs in a small FIFO and hands them to decode over valid/ready.
// A redirect clears the buffer and discards every response still in flight.
// Optional feature macro: IFU_PERF_EN adds perf_fetch_cnt, perf_flush_cnt and perf_bubble_cnt outputs.
module ifu_fetch #(
  parameter logic [63:0] RESET_PC        = 64'h0000_0000_8000_0000,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_inst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc
`ifdef IFU_PERF_EN
  ,
  output logic [63:0] perf_fetch_cnt,
  output logic [63:0] perf_flush_cnt,
  output logic [63:0] perf_bubble_cnt
`endif
);

  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam int OUT_W    = $clog2(MAX_OUTSTANDING + 1);
  localparam int IF_PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [IF_PTR_W-1:0] IF_LAST = IF_PTR_W'(MAX_OUTSTANDING - 1);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t              state_reg, state_next;
  logic [63:0]         fetch_pc_reg;
  logic [OUT_W-1:0]    outstanding_reg;
  logic [OUT_W-1:0]    drop_cnt_reg, drop_cnt_next;
  logic [OUT_W-1:0]    redirect_drop;

  // In-flight PC queue: one entry per accepted, not yet answered request.
  logic [63:0]         if_pc_reg [MAX_OUTSTANDING];
  logic [IF_PTR_W-1:0] if_wr_ptr_reg, if_rd_ptr_reg;
  logic [MAX_OUTSTANDING-1:0] if_we;

  // Instruction buffer.
  logic [63:0]         fifo_pc_reg   [FIFO_DEPTH];
  logic [31:0]         fifo_inst_reg [FIFO_DEPTH];
  logic [PTR_W-1:0]    fifo_wr_ptr_reg, fifo_rd_ptr_reg;
  logic [CNT_W-1:0]    fifo_count_reg;
  logic [FIFO_DEPTH-1:0] fifo_we;

  logic req_allowed, req_valid_int, req_fire;
  logic resp_pop, fifo_push, fifo_pop, fifo_empty;

  function automatic logic [IF_PTR_W-1:0] if_ptr_inc(input logic [IF_PTR_W-1:0] p);
    return (p == IF_LAST) ? '0 : p + IF_PTR_W'(1);
  endfunction

  // Credit rule: never issue a request whose response could not find a FIFO slot.
  assign req_allowed = (int'(outstanding_reg) < MAX_OUTSTANDING) &&
                       ((int'(fifo_count_reg) + int'(outstanding_reg)) < FIFO_DEPTH);

  assign imem_req_valid = rst_n && req_valid_int;
  assign imem_req_addr  = rst_n ? fetch_pc_reg : RESET_PC;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign resp_pop      = imem_resp_valid && (outstanding_reg != '0);
  assign fifo_push     = resp_pop && (state_reg == ST_RUN) && !redirect_valid;
  assign redirect_drop = outstanding_reg - OUT_W'(resp_pop);

  assign fifo_empty = (fifo_count_reg == '0);
  assign out_valid  = rst_n && !fifo_empty && !redirect_valid;
  assign fifo_pop   = out_valid && out_ready;
  assign out_pc     = (rst_n && !fifo_empty) ? fifo_pc_reg[fifo_rd_ptr_reg] : '0;
  assign out_inst   = (rst_n && !fifo_empty) ? fifo_inst_reg[fifo_rd_ptr_reg] : '0;

  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo_we
    assign fifo_we[gi] = fifo_push && (fifo_wr_ptr_reg == PTR_W'(gi));
  end

  for (genvar gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_if_we
    assign if_we[gi] = req_fire && (if_wr_ptr_reg == IF_PTR_W'(gi));
  end

  // Next-state logic: request gating and drop accounting for RUN/FLUSH.
  always_comb begin
    state_next    = state_reg;
    drop_cnt_next = drop_cnt_reg;
    req_valid_int = 1'b0;
    case (state_reg)
      ST_RUN: begin
        req_valid_int = !redirect_valid && req_allowed;
        if (redirect_valid) begin
          drop_cnt_next = redirect_drop;
          state_next    = (redirect_drop != '0) ? ST_FLUSH : ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (redirect_valid) begin
          drop_cnt_next = redirect_drop;
          state_next    = (redirect_drop != '0) ? ST_FLUSH : ST_RUN;
        end else if (drop_cnt_reg == '0) begin
          state_next = ST_RUN;
        end else if (resp_pop) begin
          drop_cnt_next = drop_cnt_reg - OUT_W'(1);
          if (drop_cnt_reg == OUT_W'(1)) begin
            state_next = ST_RUN;
          end
        end
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  // Control state: FSM, fetch PC, outstanding count and queue pointers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= ST_RUN;
      drop_cnt_reg    <= '0;
      fetch_pc_reg    <= RESET_PC;
      outstanding_reg <= '0;
      if_wr_ptr_reg   <= '0;
      if_rd_ptr_reg   <= '0;
      fifo_wr_ptr_reg <= '0;
      fifo_rd_ptr_reg <= '0;
      fifo_count_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      drop_cnt_reg <= drop_cnt_next;
      if (redirect_valid) begin
        fetch_pc_reg <= redirect_pc & ~64'd3;
      end else if (req_fire) begin
        fetch_pc_reg <= fetch_pc_reg + 64'd4;
      end
      outstanding_reg <= outstanding_reg + OUT_W'(req_fire) - OUT_W'(resp_pop);
      if (req_fire) begin
        if_wr_ptr_reg <= if_ptr_inc(if_wr_ptr_reg);
      end
      if (resp_pop) begin
        if_rd_ptr_reg <= if_ptr_inc(if_rd_ptr_reg);
      end
      if (redirect_valid) begin
        fifo_wr_ptr_reg <= '0;
        fifo_rd_ptr_reg <= '0;
        fifo_count_reg  <= '0;
      end else begin
        if (fifo_push) begin
          fifo_wr_ptr_reg <= fifo_wr_ptr_reg + PTR_W'(1);
        end
        if (fifo_pop) begin
          fifo_rd_ptr_reg <= fifo_rd_ptr_reg + PTR_W'(1);
        end
        fifo_count_reg <= fifo_count_reg + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
      end
    end
  end

  // Storage writes: in-flight PCs on request accept, {pc,inst} on response push.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (if_we[i]) begin
        if_pc_reg[i] <= fetch_pc_reg;
      end
    end
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (fifo_we[i]) begin
        fifo_pc_reg[i]   <= if_pc_reg[if_rd_ptr_reg];
        fifo_inst_reg[i] <= imem_resp_data;
      end
    end
  end

`ifdef IFU_PERF_EN
  // Performance counters: accepted fetches, redirect cycles, decode bubbles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetch_cnt  <= '0;
      perf_flush_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      if (req_fire) begin
        perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
      end
      if (redirect_valid) begin
        perf_flush_cnt <= perf_flush_cnt + 64'd1;
      end
      if (!out_valid) begin
        perf_bubble_cnt <= perf_bubble_cnt + 64'd1;
      end
    end
  end
`endif

  // The memory must never answer more requests than were accepted.
  resp_without_req: assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_resp_valid && (outstanding_reg == '0)));

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: scoreboard bench for ifu_fetch.
// The reference model is the architectural instruction stream: consecutive PCs from the
// current target (reset PC or last redirect), each carrying the memory word at that PC.
`timescale 1ns/1ps
module tb_ifu_fetch;
  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        out_valid, out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
`ifdef IFU_PERF_EN
  logic [63:0] perf_fetch_cnt, perf_flush_cnt, perf_bubble_cnt;
`endif

  always #5 clk = ~clk;

  ifu_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(4), .MAX_OUTSTANDING(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef IFU_PERF_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_flush_cnt(perf_flush_cnt),
    .perf_bubble_cnt(perf_bubble_cnt)
`endif
  );

  int total = 0;
  int bad = 0;
  int pop_cnt = 0;
  int fire_cnt = 0;
  int lat = 1;
  bit rand_ready = 1'b0;
  bit rand_resp = 1'b0;
  longint cyc = 0;

  logic [63:0] exp_q[$];
  logic [63:0] gen_pc;
  logic [63:0] fire_addr_q[$];
  int          fire_outs_q[$];

  typedef struct {
    logic [63:0] addr;
    longint      due;
  } mreq_t;
  mreq_t mem_q[$];

  // Memory contents: each word is its own address, except one ebreak-like word.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a[31:0] == 32'h8000_000C) return 32'h0010_0073;
    return a[31:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic topup();
    while (exp_q.size() < 16) begin
      exp_q.push_back(gen_pc);
      gen_pc += 64'd4;
    end
  endtask

  task automatic restart_model(input logic [63:0] pc);
    exp_q.delete();
    gen_pc = pc & ~64'd3;
    topup();
  endtask

  // Advance one clock; stimulus changes land 2 time units after the edge.
  task automatic step();
    @(posedge clk);
    #2;
    topup();
  endtask

  task automatic do_redirect(input logic [63:0] pc);
    redirect_valid = 1'b1;
    redirect_pc = pc;
    restart_model(pc);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    restart_model(RESET_PC);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
      chk("rst_req_addr", imem_req_addr, RESET_PC);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_pc", out_pc, 64'd0);
      chk("rst_out_inst", 64'(out_inst), 64'd0);
      step();
    end
    rst_n = 1'b1;
  endtask

  // Memory model: in-order responses after a configurable latency.
  initial begin
    bit fire, rsp, rs;
    logic [63:0] a;
    int outs;
    imem_resp_valid = 1'b0;
    imem_resp_data = '0;
    imem_req_ready = 1'b1;
    forever begin
      @(negedge clk);
      fire = imem_req_valid && imem_req_ready;
      a = imem_req_addr;
      rsp = imem_resp_valid;
      rs = rst_n;
      outs = mem_q.size();
      @(posedge clk);
      #1;
      cyc++;
      if (!rs) begin
        mem_q.delete();
        fire_cnt = 0;
      end else begin
        if (rsp && mem_q.size() > 0) mem_q.delete(0);
        if (fire) begin
          mem_q.push_back('{addr: a, due: cyc + longint'(lat) - 1});
          fire_cnt++;
          fire_addr_q.push_back(a);
          fire_outs_q.push_back(outs);
        end
      end
      if (mem_q.size() > 0 && mem_q[0].due <= cyc && (!rand_resp || $urandom_range(0, 3) != 0)) begin
        imem_resp_valid = 1'b1;
        imem_resp_data = mem_word(mem_q[0].addr);
      end else begin
        imem_resp_valid = 1'b0;
        imem_resp_data = $urandom;
      end
      imem_req_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Monitor: every decode handshake must match the head of the expected stream.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && out_valid && out_ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL out_unexpected: got pc %h expected no output", out_pc);
        end else begin
          e = exp_q.pop_front();
          $display("pop pc=%h inst=%h", out_pc, out_inst);
          chk("out_pc", out_pc, e);
          chk("out_inst", 64'(out_inst), 64'(mem_word(e)));
        end
      end else if (rst_n === 1'b1 && !out_valid && !redirect_valid) begin
        chk("empty_out_pc", out_pc, 64'd0);
        chk("empty_out_inst", 64'(out_inst), 64'd0);
      end
    end
  end

  // Watchdog.
  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int p0, r;
    out_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    rst_n = 1'b0;
    gen_pc = RESET_PC;
    do_reset(3);

    // T1: free-flowing fetch from reset, one-cycle memory.
    @(negedge clk);
    chk("t1_first_req_valid", 64'(imem_req_valid), 64'd1);
    chk("t1_first_req_addr", imem_req_addr, RESET_PC);
    step();
    @(negedge clk);
    chk("t1_no_bypass", 64'(out_valid), 64'd0);
    step();
    @(negedge clk);
    chk("t1_first_out_valid", 64'(out_valid), 64'd1);
    repeat (10) step();
    do_redirect(64'h0000_0000_8000_0040);
    @(negedge clk);
    chk("t1_redir_req_valid", 64'(imem_req_valid), 64'd0);
    chk("t1_redir_out_valid", 64'(out_valid), 64'd0);
    step();
    redirect_valid = 1'b0;
    repeat (10) step();
`ifdef IFU_PERF_EN
    @(negedge clk);
    chk("t6_perf_flush", perf_flush_cnt, 64'd1);
    chk("t6_perf_fetch", perf_fetch_cnt, 64'(fire_cnt));
`endif

    // T2: decode stalled from reset; credit limits fetch to the buffer depth.
    out_ready = 1'b0;
    do_reset(1);
    repeat (20) step();
    @(negedge clk);
    chk("t2_fire_cnt", 64'(fire_cnt), 64'd4);
    chk("t2_req_blocked", 64'(imem_req_valid), 64'd0);
    chk("t2_out_valid", 64'(out_valid), 64'd1);
    chk("t2_out_pc_hold", out_pc, RESET_PC);
    step();
    fire_addr_q.delete();
    fire_outs_q.delete();
    out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (fire_addr_q.size() > 0) seen = 1'b1;
    end
    chk("t2_resume_seen", 64'(seen), 64'd1);
    if (seen) chk("t2_resume_addr", fire_addr_q[0], 64'h0000_0000_8000_0010);

    // T3: latency 3 with two requests in flight, then redirect.
    lat = 3;
    repeat (10) step();
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (mem_q.size() == 2 && !imem_resp_valid) seen = 1'b1;
    end
    chk("t3_two_outstanding", 64'(seen), 64'd1);
    fire_addr_q.delete();
    fire_outs_q.delete();
    do_redirect(64'h0000_0000_8000_0100);
    @(negedge clk);
    chk("t3_redir_req_valid", 64'(imem_req_valid), 64'd0);
    step();
    redirect_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      step();
      if (fire_addr_q.size() > 0) seen = 1'b1;
    end
    chk("t3_refetch_seen", 64'(seen), 64'd1);
    if (seen) begin
      chk("t3_refetch_addr", fire_addr_q[0], 64'h0000_0000_8000_0100);
      chk("t3_flush_drained", 64'(fire_outs_q[0]), 64'd0);
    end
    repeat (10) step();

    // T4: misaligned redirect target, issued while a response is arriving.
    lat = 1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (imem_resp_valid) seen = 1'b1;
    end
    chk("t4_resp_present", 64'(seen), 64'd1);
    do_redirect(64'h0000_0000_8000_0102);
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("t4_aligned_addr", imem_req_addr, 64'h0000_0000_8000_0100);
    repeat (10) step();

    // T5: fill the buffer, then a one-cycle reset must discard it.
    step();
    do_redirect(64'h0000_0000_8000_0200);
    out_ready = 1'b0;
    step();
    redirect_valid = 1'b0;
    repeat (15) step();
    @(negedge clk);
    chk("t5_full_valid", 64'(out_valid), 64'd1);
    chk("t5_full_head", out_pc, 64'h0000_0000_8000_0200);
    step();
    do_reset(1);
    @(negedge clk);
    chk("t5_post_rst_valid", 64'(out_valid), 64'd0);
    chk("t5_post_rst_addr", imem_req_addr, RESET_PC);
    step();
    out_ready = 1'b1;
    repeat (20) step();

    // Randomised traffic: stalls, variable latency, redirects (incl. 64-bit wrap), resets.
    rand_ready = 1'b1;
    rand_resp = 1'b1;
    do_redirect(64'hFFFF_FFFF_FFFF_FFF4);
    for (int i = 0; i < 2500; i++) begin
      step();
      redirect_valid = 1'b0;
      if ($urandom_range(0, 7) == 0) lat = $urandom_range(1, 4);
      out_ready = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 199);
      if (r < 6) do_redirect({$urandom, $urandom});
      else if (r == 6) do_reset(1);
    end
    step();
    redirect_valid = 1'b0;

    // Liveness: with everything free-flowing the stream must keep moving.
    rand_ready = 1'b0;
    rand_resp = 1'b0;
    lat = 1;
    out_ready = 1'b1;
    repeat (5) step();
    p0 = pop_cnt;
    repeat (30) step();
    chk("liveness_pops", 64'(pop_cnt - p0 >= 10), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
